// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified memory between I- and D-cache miss handlers.
// Define MEM_ARB_RR_EN for round-robin tie-break; default gives D fixed priority.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  localparam int IdxW = $clog2(WORDS_PER_BLOCK)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [15:0]     i_addr,
  input  logic            d_req,
  input  logic            d_wr,
  input  logic [15:0]     d_addr,
  input  logic [15:0]     d_wdata,
  output logic [15:0]     mem_addr,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [15:0]     mem_wdata,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_rvalid,
  output logic [15:0]     fill_data,
  output logic [IdxW-1:0] fill_idx,
  output logic            i_fill_valid,
  output logic            d_fill_valid,
  output logic            i_done,
  output logic            d_done
);

  typedef enum logic [1:0] { IDLE, FILL, WRITE } state_t;

  localparam logic [IdxW:0] CntFull = WORDS_PER_BLOCK[IdxW:0];
  localparam logic [IdxW:0] CntOne  = 1;
  localparam logic [15:0]   BaseMask = ~16'(2 * WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY < 1) begin : gBadLatency
    $error("mem_arbiter: MEM_LATENCY must be at least 1");
  end

  state_t        stateQ;
  state_t        stateNext;
  logic          ownerIsD;
  logic [15:0]   addrQ;
  logic [15:0]   wdataQ;
  logic [IdxW:0] issCnt;
  logic [IdxW:0] retCnt;
  logic          fillValid;
  logic          grant;
  logic          grantD;
  logic          issue;
  logic          accept;
  logic          lastRet;

`ifdef MEM_ARB_RR_EN
  logic lastIsD;

  assign grantD = d_req & (~i_req | ~lastIsD);

  always_ff @(posedge clk) begin
    if (rst) begin
      lastIsD <= 1'b1;
    end else if (grant) begin
      lastIsD <= grantD;
    end
  end
`else
  assign grantD = d_req;
`endif

  assign grant   = (stateQ == IDLE) & (i_req | d_req);
  assign issue   = (stateQ == FILL) & (issCnt != CntFull);
  // returns beyond a full block are dropped
  assign accept  = (stateQ == FILL) & mem_rvalid & (retCnt != CntFull);
  assign lastRet = (stateQ == FILL) & (retCnt == CntFull);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      ownerIsD  <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      issCnt    <= '0;
      retCnt    <= '0;
      fillValid <= 1'b0;
      fill_data <= '0;
      fill_idx  <= '0;
    end else begin
      stateQ    <= stateNext;
      fillValid <= accept;
      if (grant) begin
        ownerIsD <= grantD;
        addrQ    <= grantD ? d_addr : i_addr;
        wdataQ   <= d_wdata;
        issCnt   <= '0;
        retCnt   <= '0;
      end
      if (issue) begin
        issCnt <= issCnt + CntOne;
      end
      if (accept) begin
        fill_data <= mem_rdata;
        fill_idx  <= retCnt[IdxW-1:0];
        retCnt    <= retCnt + CntOne;
      end
    end
  end

  always_comb begin
    stateNext = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (grant) begin
          stateNext = (grantD & d_wr) ? WRITE : FILL;
        end
      end
      FILL: begin
        if (lastRet) begin
          stateNext = IDLE;
        end
      end
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    unique case (stateQ)
      FILL: begin
        mem_en   = issue;
        mem_addr = (addrQ & BaseMask)
                 | 16'({issCnt[IdxW-1:0], 1'b0});
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addrQ & 16'hFFFE;
        mem_wdata = wdataQ;
      end
      default: ;
    endcase
  end

  assign i_fill_valid = fillValid & ~ownerIsD;
  assign d_fill_valid = fillValid & ownerIsD;
  assign i_done       = lastRet & ~ownerIsD;
  assign d_done       = (lastRet & ownerIsD) | (stateQ == WRITE);

endmodule
